// File: rtl/lsu_pkg.sv
// Shared types for the RV32I load/store unit (funct3 codes, FSM states, sizes).
// Optional feature macro used by the LSU: LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [2:0] {
    IDLE,
    LD_WAIT,
    LD_CAPTURE,
    RMW_WAIT,
    RMW_MERGE,
    ST_COMMIT
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  // Reserved load codes (011, 110, 111) fall through to word.
  function automatic size_e load_size(input logic [2:0] f3);
    size_e s;
    s = SZ_WORD;
    unique case (1'b1)
      (f3 == F3_LB) || (f3 == F3_LBU): s = SZ_BYTE;
      (f3 == F3_LH) || (f3 == F3_LHU): s = SZ_HALF;
      default:                         s = SZ_WORD;
    endcase
    return s;
  endfunction

  // Stores only look at the low two bits; 10 and 11 are word.
  function automatic size_e store_size(input logic [2:0] f3);
    size_e s;
    s = SZ_WORD;
    unique case (1'b1)
      (f3[1:0] == F3_SB[1:0]): s = SZ_BYTE;
      (f3[1:0] == F3_SH[1:0]): s = SZ_HALF;
      default:                 s = SZ_WORD;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus of the load/store unit.
// slave = LSU side, master = pipeline plus memory side.
interface lsu_if #(
  parameter int ADDR_WIDTH = 10
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  is_load;
  logic                  is_store;
  logic [2:0]            funct3;
  logic [31:0]           addr;
  logic [31:0]           store_data;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [31:0]           mem_data_in;
  logic                  mem_read_en;
  logic                  mem_write_en;
  logic [31:0]           mem_data;
  logic                  resp_valid;
  logic [31:0]           load_data;
  logic                  misaligned;

  modport slave (
    input  req_valid, is_load, is_store, funct3,
    input  addr, store_data, mem_data,
    output req_ready, mem_address, mem_data_in,
    output mem_read_en, mem_write_en,
    output resp_valid, load_data, misaligned
  );

  modport master (
    output req_valid, is_load, is_store, funct3,
    output addr, store_data, mem_data,
    input  req_ready, mem_address, mem_data_in,
    input  mem_read_en, mem_write_en,
    input  resp_valid, load_data, misaligned
  );

endinterface

// File: rtl/lsu_align.sv
// Lane logic: load extract/extend and byte/half merge for read-modify-write.
// Offsets arrive already aligned to the access size.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  size_e       size_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ld_o,
  output logic [31:0] st_o
);

  logic [7:0]  b;
  logic [15:0] h;

  // Select the addressed lane, then sign/zero extend.
  always_comb begin
    b    = word_i[{off_i, 3'b000} +: 8];
    h    = off_i[1] ? word_i[31:16] : word_i[15:0];
    ld_o = word_i;
    unique case (size_i)
      SZ_BYTE: ld_o = {{24{~uns_i & b[7]}}, b};
      SZ_HALF: ld_o = {{16{~uns_i & h[15]}}, h};
      default: ld_o = word_i;
    endcase
  end

  // Splice new store data into the old word.
  always_comb begin
    st_o = word_i;
    unique case (size_i)
      SZ_BYTE: st_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      SZ_HALF: st_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: st_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit in front of a word memory without byte enables.
// Macro LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of aligning.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
  lsu_if.slave bus
);

  state_e                state_q, state_d;
  size_e                 size_q, size_d;
  logic [1:0]            off_q, off_d;
  logic                  uns_q, uns_d;
  logic [DATA_WIDTH-1:0] sdata_q, sdata_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] ldata_q, ldata_d;
  logic                  re_q, re_d;
  logic                  we_q, we_d;
  logic                  rv_q, rv_d;
  logic                  mis_q, mis_d;

  size_e                 req_sz;
  logic [1:0]            req_off;
  logic                  req_mis;
  logic [DATA_WIDTH-1:0] ld_ext;
  logic [DATA_WIDTH-1:0] st_merged;
  logic                  unused_addr;

  assign unused_addr = ^bus.addr[31:ADDR_WIDTH+2];

  // Decode size and aligned lane offset of the incoming request.
  always_comb begin
    req_sz  = bus.is_load ? load_size(bus.funct3)
                          : store_size(bus.funct3);
    req_off = 2'b00;
    unique case (req_sz)
      SZ_BYTE: req_off = bus.addr[1:0];
      SZ_HALF: req_off = {bus.addr[1], 1'b0};
      default: req_off = 2'b00;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_mis = (req_sz == SZ_HALF && bus.addr[0]) ||
                   (req_sz == SZ_WORD && bus.addr[1:0] != 2'b00);
`else
  assign req_mis = 1'b0;
`endif

  lsu_align u_align (
    .word_i (bus.mem_data),
    .off_i  (off_q),
    .size_i (size_q),
    .uns_i  (uns_q),
    .wdata_i(sdata_q),
    .ld_o   (ld_ext),
    .st_o   (st_merged)
  );

  // Next state; enables and the response pulse default low.
  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    off_d   = off_q;
    uns_d   = uns_q;
    sdata_d = sdata_q;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    ldata_d = ldata_q;
    re_d    = 1'b0;
    we_d    = 1'b0;
    rv_d    = 1'b0;
    mis_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          size_d  = req_sz;
          off_d   = req_off;
          uns_d   = bus.funct3[2];
          sdata_d = bus.store_data;
          if (!bus.is_load && !bus.is_store) begin
            rv_d = 1'b1;
          end else if (req_mis) begin
            rv_d  = 1'b1;
            mis_d = 1'b1;
          end else begin
            maddr_d = bus.addr[ADDR_WIDTH+1:2];
            if (bus.is_load) begin
              re_d    = 1'b1;
              state_d = LD_WAIT;
            end else if (req_sz == SZ_WORD) begin
              wdata_d = bus.store_data;
              we_d    = 1'b1;
              state_d = ST_COMMIT;
            end else begin
              re_d    = 1'b1;
              state_d = RMW_WAIT;
            end
          end
        end
      end
      LD_WAIT:    state_d = LD_CAPTURE;
      LD_CAPTURE: begin
        ldata_d = ld_ext;
        rv_d    = 1'b1;
        state_d = IDLE;
      end
      RMW_WAIT:   state_d = RMW_MERGE;
      RMW_MERGE: begin
        wdata_d = st_merged;
        we_d    = 1'b1;
        state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        rv_d    = 1'b1;
        state_d = IDLE;
      end
      default:    state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any sequence in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      size_q  <= SZ_WORD;
      off_q   <= 2'b00;
      uns_q   <= 1'b0;
      sdata_q <= '0;
      maddr_q <= '0;
      wdata_q <= '0;
      ldata_q <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      rv_q    <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      off_q   <= off_d;
      uns_q   <= uns_d;
      sdata_q <= sdata_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      ldata_q <= ldata_d;
      re_q    <= re_d;
      we_q    <= we_d;
      rv_q    <= rv_d;
      mis_q   <= mis_d;
    end
  end

  assign bus.req_ready    = (state_q == IDLE);
  assign bus.mem_address  = maddr_q;
  assign bus.mem_data_in  = wdata_q;
  assign bus.mem_read_en  = re_q;
  assign bus.mem_write_en = we_q;
  assign bus.resp_valid   = rv_q;
  assign bus.load_data    = ldata_q;
  assign bus.misaligned   = mis_q;

endmodule
